// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: CPU fetch, CPU load/store and memory macro signals.
// Modports: master = CPU/memory side, slave = arbiter side.
interface cpu_mem_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_cs;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output instr_req, instr_addr,
    output data_req, data_we, data_addr, data_wdata,
    output mem_rdata,
    input  instr_gnt, instr_rvalid, instr_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  instr_req, instr_addr,
    input  data_req, data_we, data_addr, data_wdata,
    input  mem_rdata,
    output instr_gnt, instr_rvalid, instr_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-port synchronous memory between the
// CPU fetch port and the CPU load/store port, one access at a time.
// Ports: clk; rst (synchronous, active-high);
//   bus (cpu_mem_arbiter_if.slave): instr_* fetch port, data_* load/store
//   port, mem_* memory macro side.
// Parameter RD_LAT: memory read latency in cycles, 1..7.
// Define CPU_MEM_ARB_RR_EN for a round-robin tie-break; otherwise the
// data port wins every tie.
module cpu_mem_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  cpu_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RWAIT,
    RESP
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        own_d;
  logic [3:0]  we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] irdata_q;
  logic [31:0] drdata_q;
  logic        any_req;
  logic        pick_d;
  logic        take;
  logic        done;

  assign any_req = bus.instr_req | bus.data_req;
  assign take    = (state == IDLE) & any_req;
  assign done    = (state == RWAIT) & (cnt == 3'd0);

`ifdef CPU_MEM_ARB_RR_EN
  logic last_d;

  // A tie goes to the port that was not granted most recently.
  assign pick_d = bus.data_req & ~(bus.instr_req & last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (take) begin
      last_d <= pick_d;
    end
  end
`else
  assign pick_d = bus.data_req;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (any_req) state_n = ISSUE;
      end
      ISSUE: begin
        // we_q is zero for every fetch, so nonzero means a store.
        if (|we_q) begin
          state_n = IDLE;
        end else begin
          cnt_n   = LAT_M1;
          state_n = RWAIT;
        end
      end
      RWAIT: begin
        if (cnt == 3'd0) state_n = RESP;
        else cnt_n = cnt - 3'd1;
      end
      RESP: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      own_d    <= 1'b0;
      we_q     <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      irdata_q <= 32'd0;
      drdata_q <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take) begin
        own_d  <= pick_d;
        we_q   <= pick_d ? bus.data_we : 4'd0;
        addr_q <= pick_d ? bus.data_addr : bus.instr_addr;
        if (pick_d) wdata_q <= bus.data_wdata;
      end
      if (done) begin
        if (own_d) drdata_q <= bus.mem_rdata;
        else irdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_cs       = (state == ISSUE);
  assign bus.mem_we       = (state == ISSUE) ? we_q : 4'd0;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.instr_gnt    = (state == ISSUE) & ~own_d;
  assign bus.data_gnt     = (state == ISSUE) & own_d;
  assign bus.instr_rvalid = (state == RESP) & ~own_d;
  assign bus.data_rvalid  = (state == RESP) & own_d;
  assign bus.instr_rdata  = irdata_q;
  assign bus.data_rdata   = drdata_q;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: three arbiters (RD_LAT 1, 2, 7) share one set of
// request inputs; each has its own memory responder.
module tb_cpu_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic instr_req, data_req;
  logic [31:0] instr_addr, data_addr, data_wdata;
  logic [3:0] data_we;
  logic [2:0] igo, dgo, irv, drv, cs;
  logic [2:0][3:0] mwe;
  logic [2:0][31:0] maddr, mwdata, irdata, drdata;
  int n_chk, n_fail, cyc;

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0010_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 7);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 7);
    cpu_mem_arbiter_if bus();
    cpu_mem_arbiter #(.RD_LAT(L)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );
    int d = 0;
    logic [31:0] ra = 32'd0;
    assign bus.instr_req  = instr_req;
    assign bus.instr_addr = instr_addr;
    assign bus.data_req   = data_req;
    assign bus.data_we    = data_we;
    assign bus.data_addr  = data_addr;
    assign bus.data_wdata = data_wdata;
    assign igo[g]    = bus.instr_gnt;
    assign dgo[g]    = bus.data_gnt;
    assign irv[g]    = bus.instr_rvalid;
    assign drv[g]    = bus.data_rvalid;
    assign cs[g]     = bus.mem_cs;
    assign mwe[g]    = bus.mem_we;
    assign maddr[g]  = bus.mem_addr;
    assign mwdata[g] = bus.mem_wdata;
    assign irdata[g] = bus.instr_rdata;
    assign drdata[g] = bus.data_rdata;
    // Memory: read data is valid only in the cycle L after mem_cs,
    // random garbage otherwise.
    always @(negedge clk) begin
      if (d == 1) bus.mem_rdata <= memval(ra);
      else bus.mem_rdata <= $urandom;
      if (bus.mem_cs && bus.mem_we == 4'd0) begin
        d  <= L;
        ra <= bus.mem_addr;
      end else if (d != 0) begin
        d <= d - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    instr_req = 0; data_req = 0; data_we = 0;
    instr_addr = 0; data_addr = 0; data_wdata = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    instr_req = 1; instr_addr = 32'h0000_0040;
    data_req = 1; data_we = 4'd0; data_addr = 32'h0000_0080;
    for (int k = 0; k < 25; k++) tick();
    rst = 1;
    tick();
    rst = 0;
    cyc = 0;
    instr_req = 0; data_req = 0;
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if ({igo[g], dgo[g], irv[g], drv[g], cs[g]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_ctl L=%0d got=%b exp=0", lat_of(g),
                 {igo[g], dgo[g], irv[g], drv[g], cs[g]});
      end
      n_chk++;
      if (mwe[g] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_we L=%0d got=%h exp=0", lat_of(g), mwe[g]);
      end
      n_chk++;
      if (maddr[g] !== 32'd0 || mwdata[g] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mem L=%0d got=%h/%h exp=0", lat_of(g),
                 maddr[g], mwdata[g]);
      end
      n_chk++;
      if (irdata[g] !== 32'd0 || drdata[g] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_rdata L=%0d got=%h/%h exp=0", lat_of(g),
                 irdata[g], drdata[g]);
      end
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    instr_req = 1; instr_addr = 32'h0000_0010;
    tick();
    instr_req = 0;
    n_chk++;
    if ({igo[0], cs[0], dgo[0]} !== 3'b110 || mwe[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL fetch_gnt got=%b we=%h exp=110 we=0",
               {igo[0], cs[0], dgo[0]}, mwe[0]);
    end
    n_chk++;
    if (maddr[0] !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL fetch_addr got=%h exp=00000010", maddr[0]);
    end
    tick();
    n_chk++;
    if (irv[0] !== 1'b0 || cs[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_t2 rv=%b cs=%b exp=0/0", irv[0], cs[0]);
    end
    tick();
    n_chk++;
    if (irv[0] !== 1'b1 || irdata[0] !== 32'h0010_0093) begin
      n_fail++;
      $display("FAIL fetch_rv rv=%b data=%h exp=1 00100093",
               irv[0], irdata[0]);
    end
    tick();
    n_chk++;
    if (irv[0] !== 1'b0 || irdata[0] !== 32'h0010_0093) begin
      n_fail++;
      $display("FAIL fetch_hold rv=%b data=%h exp=0 00100093",
               irv[0], irdata[0]);
    end
  endtask

  task automatic test_store();
    do_reset();
    data_req = 1; data_we = 4'b0100;
    data_addr = 32'h0000_8002; data_wdata = 32'h00AB_0000;
    tick();
    data_req = 0;
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if ({cs[g], dgo[g], igo[g]} !== 3'b110 || mwe[g] !== 4'b0100) begin
        n_fail++;
        $display("FAIL store_issue L=%0d got=%b we=%h exp=110 we=4",
                 lat_of(g), {cs[g], dgo[g], igo[g]}, mwe[g]);
      end
      n_chk++;
      if (maddr[g] !== 32'h0000_8002 || mwdata[g] !== 32'h00AB_0000) begin
        n_fail++;
        $display("FAIL store_bus L=%0d got=%h/%h exp=00008002/00ab0000",
                 lat_of(g), maddr[g], mwdata[g]);
      end
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        n_chk++;
        if ({cs[g], drv[g], dgo[g]} !== 3'b0 || mwe[g] !== 4'd0) begin
          n_fail++;
          $display("FAIL store_after L=%0d cyc=%0d got=%b we=%h exp=0",
                   lat_of(g), cyc, {cs[g], drv[g], dgo[g]}, mwe[g]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic e1_d;
    logic [31:0] a1, a2;
`ifdef CPU_MEM_ARB_RR_EN
    e1_d = 1'b0;
`else
    e1_d = 1'b1;
`endif
    a1 = e1_d ? 32'h0000_2000 : 32'h0000_1000;
    a2 = e1_d ? 32'h0000_1000 : 32'h0000_2000;
    do_reset();
    instr_req = 1; instr_addr = 32'h0000_1000;
    data_req = 1; data_we = 4'd0; data_addr = 32'h0000_2000;
    tick();
    n_chk++;
    if (dgo[1] !== e1_d || igo[1] !== !e1_d) begin
      n_fail++;
      $display("FAIL sim_first d=%b i=%b exp d=%b", dgo[1], igo[1], e1_d);
    end
    if (e1_d) data_req = 0;
    tick(); tick(); tick();
    n_chk++;
    if ((e1_d ? drv[1] : irv[1]) !== 1'b1 ||
        (e1_d ? drdata[1] : irdata[1]) !== memval(a1)) begin
      n_fail++;
      $display("FAIL sim_rv1 irv=%b drv=%b exp data=%h", irv[1], drv[1],
               memval(a1));
    end
    tick();
    n_chk++;
    if (cs[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_gap cs=%b exp=0", cs[1]);
    end
    tick();
    n_chk++;
    if (dgo[1] !== !e1_d || igo[1] !== e1_d) begin
      n_fail++;
      $display("FAIL sim_second d=%b i=%b exp d=%b", dgo[1], igo[1], !e1_d);
    end
    instr_req = 0; data_req = 0;
    tick(); tick(); tick();
    n_chk++;
    if ((e1_d ? irv[1] : drv[1]) !== 1'b1 ||
        (e1_d ? irdata[1] : drdata[1]) !== memval(a2)) begin
      n_fail++;
      $display("FAIL sim_rv2 irv=%b drv=%b exp data=%h", irv[1], drv[1],
               memval(a2));
    end
  endtask

  task automatic test_load_lat7();
    do_reset();
    instr_req = 1; instr_addr = 32'h0000_0444;
    tick();
    instr_req = 0;
    while (cyc < 9) tick();
    n_chk++;
    if (irv[2] !== 1'b1 || irdata[2] !== memval(32'h0000_0444)) begin
      n_fail++;
      $display("FAIL l7_fetch rv=%b data=%h exp=1 %h", irv[2], irdata[2],
               memval(32'h0000_0444));
    end
    tick();
    data_req = 1; data_we = 4'd0; data_addr = 32'h0001_2344;
    tick();
    data_req = 0;
    n_chk++;
    if (dgo[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL l7_gnt got=%b exp=1", dgo[2]);
    end
    for (int k = 0; k < 9; k++) begin
      n_chk++;
      if (drv[2] !== (cyc == 19) || irdata[2] !== memval(32'h0000_0444)) begin
        n_fail++;
        $display("FAIL l7_wait cyc=%0d rv=%b idata=%h exp rv=%b", cyc,
                 drv[2], irdata[2], cyc == 19);
      end
      tick();
    end
    n_chk++;
    if (drdata[2] !== memval(32'h0001_2344) || drv[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL l7_data got=%h rv=%b exp=%h", drdata[2], drv[2],
               memval(32'h0001_2344));
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    instr_req = 1; instr_addr = 32'h0000_0200;
    tick(); tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    instr_addr = 32'h0000_0300;
    n_chk++;
    if ({igo[2], dgo[2], irv[2], drv[2], cs[2]} !== 5'b0 ||
        mwe[2] !== 4'd0 || maddr[2] !== 32'd0 || irdata[2] !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_zero ctl=%b addr=%h idata=%h exp=0",
               {igo[2], dgo[2], irv[2], drv[2], cs[2]}, maddr[2], irdata[2]);
    end
    tick();
    instr_req = 0;
    n_chk++;
    if (igo[2] !== 1'b1 || maddr[2] !== 32'h0000_0300) begin
      n_fail++;
      $display("FAIL rst_mid_gnt gnt=%b addr=%h exp=1 00000300",
               igo[2], maddr[2]);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_chk++;
      if (irv[2] !== (cyc == 14)) begin
        n_fail++;
        $display("FAIL rst_mid_rv cyc=%0d got=%b exp=%b", cyc, irv[2],
                 cyc == 14);
      end
    end
    n_chk++;
    if (irdata[2] !== memval(32'h0000_0300)) begin
      n_fail++;
      $display("FAIL rst_mid_data got=%h exp=%h", irdata[2],
               memval(32'h0000_0300));
    end
  endtask

  task automatic test_held_request();
    int first [3];
    int second [3];
    logic [2:0] prev;
    do_reset();
    instr_req = 1; instr_addr = 32'h0000_0100;
    first = '{-1, -1, -1};
    second = '{-1, -1, -1};
    prev = 3'b0;
    for (int k = 0; k < 24; k++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        n_chk++;
        if (igo[g] && prev[g]) begin
          n_fail++;
          $display("FAIL held_consec L=%0d cyc=%0d got=11 exp=10",
                   lat_of(g), cyc);
        end
        if (igo[g]) begin
          if (first[g] < 0) first[g] = cyc;
          else if (second[g] < 0) second[g] = cyc;
        end
      end
      prev = igo;
    end
    instr_req = 0;
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (first[g] != 1 || second[g] != 1 + lat_of(g) + 3) begin
        n_fail++;
        $display("FAIL held_gnt L=%0d got=%0d,%0d exp=1,%0d", lat_of(g),
                 first[g], second[g], 1 + lat_of(g) + 3);
      end
    end
  endtask

  task automatic test_random(input int s);
    int L, gi, gd, m_ic, m_free;
    bit pi, pd, pick_d, e_cs, e_rv, m_own_d;
    logic [3:0] m_we;
    logic [31:0] m_addr, m_wd, m_ird, m_drd;
`ifdef CPU_MEM_ARB_RR_EN
    bit m_last_d;
    m_last_d = 1;
`endif
    L = lat_of(s);
    do_reset();
    m_ic = -100; m_free = 0; m_own_d = 0; m_we = 0;
    m_addr = 0; m_wd = 0; m_ird = 0; m_drd = 0;
    pi = 0; pd = 0; gi = 0; gd = 1;
    for (int k = 0; k < 300; k++) begin
      if (m_ic == cyc - 1) begin
        if (m_own_d) begin pd = 0; gd = $urandom_range(0, 3); end
        else begin pi = 0; gi = $urandom_range(0, 3); end
      end
      if (!pi) begin
        if (gi == 0) begin pi = 1; instr_addr = $urandom; end
        else gi--;
      end
      if (!pd) begin
        if (gd == 0) begin
          pd = 1; data_addr = $urandom; data_wdata = $urandom;
          data_we = ($urandom_range(0, 1) == 1) ?
                    4'($urandom_range(1, 15)) : 4'd0;
        end else gd--;
      end
      instr_req = pi; data_req = pd;
      if (cyc >= m_free && (pi || pd)) begin
`ifdef CPU_MEM_ARB_RR_EN
        pick_d = (pi && pd) ? !m_last_d : pd;
        m_last_d = pick_d;
`else
        pick_d = pd;
`endif
        m_own_d = pick_d;
        m_we = pick_d ? data_we : 4'd0;
        m_addr = pick_d ? data_addr : instr_addr;
        if (pick_d) m_wd = data_wdata;
        m_ic = cyc + 1;
        m_free = (m_we != 4'd0) ? cyc + 2 : cyc + 3 + L;
      end
      tick();
      e_cs = (cyc == m_ic);
      e_rv = (m_we == 4'd0) && (cyc == m_ic + 1 + L);
      if (e_rv) begin
        if (m_own_d) m_drd = memval(m_addr);
        else m_ird = memval(m_addr);
      end
      n_chk++;
      if (cs[s] !== e_cs || mwe[s] !== (e_cs ? m_we : 4'd0)) begin
        n_fail++;
        $display("FAIL rnd_cs L=%0d cyc=%0d got=%b/%h exp=%b/%h", L, cyc,
                 cs[s], mwe[s], e_cs, e_cs ? m_we : 4'd0);
      end
      n_chk++;
      if (igo[s] !== (e_cs && !m_own_d) || dgo[s] !== (e_cs && m_own_d)) begin
        n_fail++;
        $display("FAIL rnd_gnt L=%0d cyc=%0d got i=%b d=%b exp i=%b d=%b",
                 L, cyc, igo[s], dgo[s], e_cs && !m_own_d, e_cs && m_own_d);
      end
      n_chk++;
      if (maddr[s] !== m_addr) begin
        n_fail++;
        $display("FAIL rnd_addr L=%0d cyc=%0d got=%h exp=%h", L, cyc,
                 maddr[s], m_addr);
      end
      if (e_cs && m_own_d) begin
        n_chk++;
        if (mwdata[s] !== m_wd) begin
          n_fail++;
          $display("FAIL rnd_wdata L=%0d cyc=%0d got=%h exp=%h", L, cyc,
                   mwdata[s], m_wd);
        end
      end
      n_chk++;
      if (irv[s] !== (e_rv && !m_own_d) || drv[s] !== (e_rv && m_own_d)) begin
        n_fail++;
        $display("FAIL rnd_rv L=%0d cyc=%0d got i=%b d=%b exp i=%b d=%b",
                 L, cyc, irv[s], drv[s], e_rv && !m_own_d, e_rv && m_own_d);
      end
      n_chk++;
      if (irdata[s] !== m_ird || drdata[s] !== m_drd) begin
        n_fail++;
        $display("FAIL rnd_rdata L=%0d cyc=%0d got=%h/%h exp=%h/%h", L, cyc,
                 irdata[s], drdata[s], m_ird, m_drd);
      end
    end
    instr_req = 0; data_req = 0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1; instr_req = 0; data_req = 0; data_we = 0;
    instr_addr = 0; data_addr = 0; data_wdata = 0;
    tick();
    tick();
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_load_lat7();
    test_reset_mid_read();
    test_held_request();
    for (int s = 0; s < 3; s++) test_random(s);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end
endmodule
